// File: rtl/median3x3_pkg.sv
// median3x3_pkg: shared defaults, counter widths and the 3-input sort result type
// for the median3x3_window slice.
package median3x3_pkg;
    localparam int DEF_DATA_LENGTH = 8;
    localparam int DEF_W = 100;
    localparam int DEF_H = 100;
    localparam int DEF_COL_W = $clog2(DEF_W);
    localparam int DEF_ROW_W = $clog2(DEF_H);
    typedef logic [DEF_DATA_LENGTH-1:0] pix_t;
    typedef struct packed {
        pix_t lo;
        pix_t mid;
        pix_t hi;
    } sort3_t;
endpackage

// File: rtl/median3x3_window_sort.sv
// median3_sort: combinational unsigned 3-input sorter producing {lo, mid, hi}.
module median3_sort
    import median3x3_pkg::*;
(
    input  pix_t   a_i,
    input  pix_t   b_i,
    input  pix_t   c_i,
    output sort3_t s_o
);
    pix_t lo_ab, hi_ab;
    assign lo_ab    = (a_i < b_i) ? a_i : b_i;
    assign hi_ab    = (a_i < b_i) ? b_i : a_i;
    assign s_o.lo   = (c_i < lo_ab) ? c_i : lo_ab;
    assign s_o.hi   = (c_i > hi_ab) ? c_i : hi_ab;
    assign s_o.mid  = (c_i < lo_ab) ? lo_ab : ((c_i > hi_ab) ? hi_ab : c_i);
endmodule

// File: rtl/median3x3_window.sv
// median3x3_window: 3x3 window fed by two line buffers, 3-stage median pipeline
// with centre coordinates. Optional MEDIAN_BYPASS_EN adds a bypass port selecting the centre pixel.
module median3x3_window
    import median3x3_pkg::*;
#(
    parameter int DATA_LENGTH = DEF_DATA_LENGTH,
    parameter int W = DEF_W,
    parameter int H = DEF_H
) (
    input  logic                   clk,
    input  logic                   reset,
`ifdef MEDIAN_BYPASS_EN
    input  logic                   bypass,
`endif
    input  logic [DATA_LENGTH-1:0] pix_in,
    input  logic                   pix_valid,
    input  logic [DATA_LENGTH-1:0] lb1_out,
    input  logic [DATA_LENGTH-1:0] lb2_out,
    output logic                   lb_flag,
    output logic [DATA_LENGTH-1:0] med_out,
    output logic                   med_valid,
    output logic [$clog2(H)-1:0]   med_row,
    output logic [$clog2(W)-1:0]   med_col,
    output logic                   frame_done
);
    localparam int CW = $clog2(W);
    localparam int RW = $clog2(H);

    // win_q[col][row]: col 2 is the newest column, row 0 the oldest line
    pix_t            win_q [3][3];
    logic [CW-1:0]   col_q, col_d, wcol_q, s1col_q, s2col_q, med_col_q;
    logic [RW-1:0]   row_q, row_d, wrow_q, s1row_q, s2row_q, med_row_q;
    logic            col_last, row_last;
    logic            wv_q, s1v_q, s2v_q, med_valid_q, done_q;
    sort3_t          col_s [3];
    sort3_t          s1_q [3];
    sort3_t          s2_q, lo_s, mid_s, hi_s, s3_s;
    pix_t            med_q, med_d;
    logic            unused_sort_bits;

    assign lb_flag  = ~pix_valid;
    assign col_last = col_q == CW'(W - 1);
    assign row_last = row_q == RW'(H - 1);
    assign col_d    = col_last ? '0 : col_q + 1'b1;
    assign row_d    = col_last ? (row_last ? '0 : row_q + 1'b1) : row_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_q  <= '0;
            row_q  <= '0;
            wv_q   <= 1'b0;
            wrow_q <= '0;
            wcol_q <= '0;
            done_q <= 1'b0;
            for (int c = 0; c < 3; c++)
                for (int r = 0; r < 3; r++)
                    win_q[c][r] <= '0;
        end else begin
            done_q <= pix_valid && row_last && col_last;
            wv_q   <= pix_valid && row_q >= RW'(2) && col_q >= CW'(2);
            if (pix_valid) begin
                col_q    <= col_d;
                row_q    <= row_d;
                wrow_q   <= row_q - 1'b1;
                wcol_q   <= col_q - 1'b1;
                win_q[0] <= win_q[1];
                win_q[1] <= win_q[2];
                win_q[2] <= '{lb2_out, lb1_out, pix_in};
            end
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_col
        median3_sort u_col (.a_i(win_q[i][0]), .b_i(win_q[i][1]), .c_i(win_q[i][2]), .s_o(col_s[i]));
    end

    // S2: the median of 9 is the median of {max of lows, median of mids, min of highs}
    median3_sort u_lo  (.a_i(s1_q[0].lo),  .b_i(s1_q[1].lo),  .c_i(s1_q[2].lo),  .s_o(lo_s));
    median3_sort u_mid (.a_i(s1_q[0].mid), .b_i(s1_q[1].mid), .c_i(s1_q[2].mid), .s_o(mid_s));
    median3_sort u_hi  (.a_i(s1_q[0].hi),  .b_i(s1_q[1].hi),  .c_i(s1_q[2].hi),  .s_o(hi_s));
    median3_sort u_s3  (.a_i(s2_q.lo),     .b_i(s2_q.mid),    .c_i(s2_q.hi),     .s_o(s3_s));

    assign unused_sort_bits = ^{lo_s.lo, lo_s.mid, mid_s.lo, mid_s.hi, hi_s.mid, hi_s.hi, s3_s.lo, s3_s.hi};

`ifdef MEDIAN_BYPASS_EN
    pix_t s1c_q, s2c_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1c_q <= '0;
            s2c_q <= '0;
        end else begin
            s1c_q <= win_q[1][1];
            s2c_q <= s1c_q;
        end
    end
    assign med_d = bypass ? s2c_q : s3_s.mid;
`else
    assign med_d = s3_s.mid;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q        <= '{default: '0};
            s1v_q       <= 1'b0;
            s1row_q     <= '0;
            s1col_q     <= '0;
            s2_q        <= '0;
            s2v_q       <= 1'b0;
            s2row_q     <= '0;
            s2col_q     <= '0;
            med_q       <= '0;
            med_valid_q <= 1'b0;
            med_row_q   <= '0;
            med_col_q   <= '0;
        end else begin
            s1_q        <= col_s;
            s1v_q       <= wv_q;
            s1row_q     <= wrow_q;
            s1col_q     <= wcol_q;
            s2_q        <= '{lo: lo_s.hi, mid: mid_s.mid, hi: hi_s.lo};
            s2v_q       <= s1v_q;
            s2row_q     <= s1row_q;
            s2col_q     <= s1col_q;
            med_q       <= med_d;
            med_valid_q <= s2v_q;
            med_row_q   <= s2row_q;
            med_col_q   <= s2col_q;
        end
    end

    assign med_out    = med_q;
    assign med_valid  = med_valid_q;
    assign med_row    = med_row_q;
    assign med_col    = med_col_q;
    assign frame_done = done_q;
endmodule
